// File: rtl/uart_dbus_bridge_pkg.sv
// Shared UART bridge / dbus definitions: command and response codes, FSM
// encoding and the initiator/responder bus structs.
package uart_dbus_bridge_pkg;

  localparam logic [7:0] UART_BR_CMD_WR = 8'h57;
  localparam logic [7:0] UART_BR_CMD_RD = 8'h52;
  localparam logic [7:0] UART_BR_ACK    = 8'h06;
  localparam logic [7:0] UART_BR_NAK    = 8'h15;

  typedef enum logic [2:0] {
    BR_IDLE  = 3'd0,
    BR_ADDR  = 3'd1,
    BR_WDATA = 3'd2,
    BR_BUS   = 3'd3,
    BR_RESP  = 3'd4,
    BR_TXGAP = 3'd5
  } type_uart_br_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

endpackage

// File: rtl/uart_dbus_bridge.sv
// UART byte-stream to dbus single-word initiator: parses W/R frames, runs one
// bus access with timeout, and serialises the ACK/NAK (+ read data) reply.
module uart_dbus_bridge
  import uart_dbus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int RX_IDLE_CYC = 65536
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_byte_i,
  input  logic            rx_valid_i,
  output logic [7:0]      tx_byte_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output type_dbus2peri_s bridge2dbus_o,
  input  type_peri2dbus_s dbus2bridge_i
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int IW = $clog2(RX_IDLE_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(RX_IDLE_CYC - 1);

  type_uart_br_state_e state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          req_q, req_d;
  logic          wen_q, wen_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [39:0]   resp_q, resp_d;
  logic [2:0]    left_q, left_d;
  logic          txv_q, txv_d;
  logic [7:0]    txb_q, txb_d;
  logic          cmd_open;

  // The last TXGAP cycle is treated as IDLE for command bytes, so a frame
  // that starts right as the reply finishes is not lost.
  assign cmd_open = (state_q == BR_IDLE) || (state_q == BR_TXGAP && left_q == 3'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    wen_d   = wen_q;
    tmo_d   = tmo_q;
    idle_d  = idle_q;
    resp_d  = resp_q;
    left_d  = left_q;
    txv_d   = 1'b0;
    txb_d   = txb_q;
    case (state_q)
      BR_ADDR, BR_WDATA: begin
        if (rx_valid_i) begin
          idle_d = '0;
          cnt_d  = cnt_q + 2'd1;
          if (state_q == BR_ADDR) addr_d  = {rx_byte_i, addr_q[31:8]};
          else                    wdata_d = {rx_byte_i, wdata_q[31:8]};
          if (cnt_q == 2'd3) begin
            if (state_q == BR_ADDR && wr_q) begin
              state_d = BR_WDATA;
            end else begin
              state_d = BR_BUS;
              req_d   = 1'b1;
              wen_d   = wr_q;
              tmo_d   = '0;
            end
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d = BR_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      BR_BUS: begin
        // ack is checked first so it wins over a coincident timeout
        if (dbus2bridge_i.ack) begin
          state_d = BR_RESP;
          req_d   = 1'b0;
          wen_d   = 1'b0;
          resp_d  = {dbus2bridge_i.r_data, UART_BR_ACK};
          left_d  = wr_q ? 3'd1 : 3'd5;
        end else if (tmo_q == TMO_LAST) begin
          state_d = BR_RESP;
          req_d   = 1'b0;
          wen_d   = 1'b0;
          resp_d  = {32'h0, UART_BR_NAK};
          left_d  = 3'd1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      BR_RESP: begin
        if (tx_ready_i) begin
          state_d = BR_TXGAP;
          txv_d   = 1'b1;
          txb_d   = resp_q[7:0];
          resp_d  = {8'h00, resp_q[39:8]};
          left_d  = left_q - 3'd1;
        end
      end
      BR_TXGAP: state_d = (left_q != 3'd0) ? BR_RESP : BR_IDLE;
      default: ;
    endcase
    if (cmd_open && rx_valid_i) begin
      case (rx_byte_i)
        UART_BR_CMD_WR, UART_BR_CMD_RD: begin
          state_d = BR_ADDR;
          wr_d    = (rx_byte_i == UART_BR_CMD_WR);
          cnt_d   = 2'd0;
          idle_d  = '0;
        end
        default: begin
          state_d = BR_RESP;
          resp_d  = {32'h0, UART_BR_NAK};
          left_d  = 3'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BR_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      tmo_q   <= '0;
      idle_q  <= '0;
      resp_q  <= '0;
      left_q  <= '0;
      txv_q   <= 1'b0;
      txb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      wen_q   <= wen_d;
      tmo_q   <= tmo_d;
      idle_q  <= idle_d;
      resp_q  <= resp_d;
      left_q  <= left_d;
      txv_q   <= txv_d;
      txb_q   <= txb_d;
    end
  end

  always_comb begin
    bridge2dbus_o        = '0;
    bridge2dbus_o.addr   = {addr_q[31:2], 2'b00};
    bridge2dbus_o.w_data = wdata_q;
    bridge2dbus_o.w_en   = wen_q;
    bridge2dbus_o.req    = req_q;
  end

  assign tx_valid_o = txv_q;
  assign tx_byte_o  = txb_q;

endmodule

// File: tb/tb_uart_dbus_bridge.sv
// Directed + randomized bench for uart_dbus_bridge: frames go in as bytes,
// bus accesses and reply bytes are logged and compared with a frame-level model.
module tb_uart_dbus_bridge;
  import uart_dbus_bridge_pkg::*;

  localparam int TMO  = 16;
  localparam int RXI  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rx_valid, tx_valid, tx_ready;
  logic [7:0] rx_byte, tx_byte;
  type_dbus2peri_s bus;
  type_peri2dbus_s dbus_in;

  uart_dbus_bridge #(.TIMEOUT_CYC(TMO), .RX_IDLE_CYC(RXI)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte_i(rx_byte), .rx_valid_i(rx_valid),
    .tx_byte_o(tx_byte), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .bridge2dbus_o(bus), .dbus2bridge_i(dbus_in)
  );

  int checks = 0;
  int passes = 0;

  // responder environment: acks after lat cycles of req, or never
  int lat = 1;
  logic never = 1'b0;
  int rdy_mode = 0;
  logic ack = 1'b0;
  logic [31:0] rdata = '0;
  int wait_cnt = 0;
  logic [31:0] bus_mem [16];
  logic bus_wr [16] = '{default: 1'b0};

  assign dbus_in.ack    = ack;
  assign dbus_in.r_data = rdata;

  always @(posedge clk) begin
    if (!rst_n) begin
      ack <= 1'b0;
      wait_cnt <= 0;
    end else if (ack) begin
      ack <= 1'b0;
      wait_cnt <= 0;
    end else if (bus.req && !never) begin
      if (wait_cnt >= lat - 1) begin
        ack <= 1'b1;
        if (bus.w_en) begin
          bus_mem[bus.addr[5:2]] <= bus.w_data;
          bus_wr[bus.addr[5:2]]  <= 1'b1;
        end else begin
          rdata <= bus_wr[bus.addr[5:2]] ? bus_mem[bus.addr[5:2]] : (bus.addr ^ 32'hA5A5_5A5A);
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ($urandom_range(0, 2) != 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // monitor: one log entry per req episode, one per tx pulse
  logic [31:0] req_a_log[$], req_d_log[$];
  logic        req_w_log[$];
  int          req_len_log[$];
  logic [7:0]  tx_log[$];
  logic req_prev = 1'b0, txv_prev = 1'b0, rdy_prev = 1'b0;
  logic [31:0] a_prev = '0, d_prev = '0;
  logic w_prev = 1'b0;
  int run = 0, gate_err = 0, unstable = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev <= 1'b0;
      txv_prev <= 1'b0;
      rdy_prev <= 1'b0;
      run <= 0;
    end else begin
      if (bus.req && !req_prev) begin
        req_a_log.push_back(bus.addr);
        req_d_log.push_back(bus.w_data);
        req_w_log.push_back(bus.w_en);
        run <= 1;
      end else if (bus.req) begin
        run <= run + 1;
        if (bus.addr != a_prev || bus.w_data != d_prev || bus.w_en != w_prev)
          unstable <= unstable + 1;
      end
      if (!bus.req && req_prev) req_len_log.push_back(run);
      if (tx_valid) begin
        tx_log.push_back(tx_byte);
        if (!rdy_prev || txv_prev) gate_err <= gate_err + 1;
      end
      req_prev <= bus.req;
      a_prev <= bus.addr;
      d_prev <= bus.w_data;
      w_prev <= bus.w_en;
      txv_prev <= tx_valid;
      rdy_prev <= tx_ready;
    end
  end

  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic clear_logs();
    req_a_log.delete(); req_d_log.delete(); req_w_log.delete();
    req_len_log.delete(); tx_log.delete();
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (tx_log.size() < n && k < 3000) begin tick(1); k++; end
    chk({tag, "_tx_wait"}, 64'(tx_log.size() >= n), 64'd1);
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                          input int l, input logic nv, input int gmax, input logic inj,
                          input string tag);
    logic [7:0] fb[$];
    logic [7:0] etx[$];
    logic [31:0] wa, rv;
    int nreq, elen;
    logic is_w, is_r;
    clear_logs();
    lat = l;
    never = nv;
    wa = {a[31:2], 2'b00};
    is_w = (cmd == UART_BR_CMD_WR);
    is_r = (cmd == UART_BR_CMD_RD);
    fb.push_back(cmd);
    if (is_w || is_r) for (int i = 0; i < 4; i++) fb.push_back(a[8*i +: 8]);
    if (is_w) for (int i = 0; i < 4; i++) fb.push_back(d[8*i +: 8]);
    nreq = 0;
    elen = 0;
    if (!is_w && !is_r) begin
      etx.push_back(UART_BR_NAK);
    end else begin
      nreq = 1;
      if (nv) begin
        elen = TMO;
        etx.push_back(UART_BR_NAK);
      end else begin
        elen = l + 1;
        etx.push_back(UART_BR_ACK);
        if (is_w) ref_mem[wa] = d;
        else begin
          rv = ref_rd(wa);
          for (int i = 0; i < 4; i++) etx.push_back(rv[8*i +: 8]);
        end
      end
    end
    for (int i = 0; i < fb.size(); i++)
      send_byte(fb[i], (i == fb.size() - 1) ? 0 : int'($urandom_range(0, gmax)));
    if (nreq != 0) chk({tag, "_req_rise"}, 64'(bus.req), 64'd1);
    if (inj) begin
      send_byte(UART_BR_CMD_WR, 0);
      send_byte(UART_BR_CMD_RD, 0);
      send_byte(8'h41, 0);
    end
    wait_tx(etx.size(), tag);
    tick(4);
    chk({tag, "_nreq"}, 64'(req_a_log.size()), 64'(nreq));
    if (nreq != 0 && req_a_log.size() != 0) begin
      chk({tag, "_addr"}, 64'(req_a_log[0]), 64'(wa));
      chk({tag, "_wen"}, 64'(req_w_log[0]), 64'(is_w));
      if (is_w) chk({tag, "_wdata"}, 64'(req_d_log[0]), 64'(d));
      if (req_len_log.size() != 0) chk({tag, "_reqlen"}, 64'(req_len_log[0]), 64'(elen));
    end
    chk({tag, "_ntx"}, 64'(tx_log.size()), 64'(etx.size()));
    for (int i = 0; i < etx.size(); i++)
      if (i < tx_log.size()) chk($sformatf("%s_tx%0d", tag, i), 64'(tx_log[i]), 64'(etx[i]));
  endtask

  initial begin
    logic [7:0]  c;
    logic [31:0] ra;
    int k;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_byte = '0;
    tick(3);
    chk("rst_req", 64'(bus.req), 64'd0);
    chk("rst_wen", 64'(bus.w_en), 64'd0);
    chk("rst_addr", 64'(bus.addr), 64'd0);
    chk("rst_wdata", 64'(bus.w_data), 64'd0);
    chk("rst_txv", 64'(tx_valid), 64'd0);
    chk("rst_txb", 64'(tx_byte), 64'd0);
    rst_n = 1'b1;
    tick(2);

    do_frame(UART_BR_CMD_WR, 32'h8000_0010, 32'hDEAD_BEEF, 1, 1'b0, 0, 1'b0, "wr");
    do_frame(UART_BR_CMD_WR, 32'h8000_0004, 32'h1234_5678, 2, 1'b0, 2, 1'b0, "wr2");
    rdy_mode = 1;
    do_frame(UART_BR_CMD_RD, 32'h8000_0004, 32'h0, 1, 1'b0, 0, 1'b0, "rd");
    do_frame(UART_BR_CMD_RD, 32'h8000_0008, 32'h0, 1, 1'b1, 0, 1'b0, "tmo");
    do_frame(UART_BR_CMD_WR, 32'h8000_0023, 32'hCAFE_F00D, 3, 1'b0, 1, 1'b0, "post_tmo");
    do_frame(8'h41, 32'h0, 32'h0, 1, 1'b0, 0, 1'b0, "unk");

    clear_logs();
    send_byte(UART_BR_CMD_RD, 0);
    send_byte(8'h04, 0);
    tick(RXI + 8);
    chk("partial_nreq", 64'(req_a_log.size()), 64'd0);
    chk("partial_ntx", 64'(tx_log.size()), 64'd0);
    do_frame(UART_BR_CMD_WR, 32'h8000_0030, 32'h0BAD_F00D, 1, 1'b0, 0, 1'b0, "post_idle");

    do_frame(UART_BR_CMD_RD, 32'h8000_0010, 32'h0, 10, 1'b0, 0, 1'b1, "inject");

    // reset while req is high
    clear_logs();
    lat = 1;
    never = 1'b1;
    send_byte(UART_BR_CMD_RD, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    tick(3);
    chk("rstbus_req_before", 64'(bus.req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbus_req", 64'(bus.req), 64'd0);
    chk("rstbus_wen", 64'(bus.w_en), 64'd0);
    chk("rstbus_txv", 64'(tx_valid), 64'd0);
    tick(2);
    rst_n = 1'b1;
    never = 1'b0;
    tick(2);

    // reset while a reply byte is being launched
    rdy_mode = 2;
    send_byte(UART_BR_CMD_RD, 0);
    send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h80, 0);
    tick(8);
    rdy_mode = 0;
    k = 0;
    while (!tx_valid && k < 50) begin tick(1); k++; end
    chk("rsttx_pulse_seen", 64'(tx_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rsttx_txv", 64'(tx_valid), 64'd0);
    chk("rsttx_txb", 64'(tx_byte), 64'd0);
    chk("rsttx_req", 64'(bus.req), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    do_frame(UART_BR_CMD_RD, 32'h8000_0010, 32'h0, 1, 1'b0, 0, 1'b0, "after_rst");

    rdy_mode = 1;
    for (int n = 0; n < 24; n++) begin
      k = int'($urandom_range(0, 9));
      ra = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if (k == 0) begin
        c = 8'($urandom_range(0, 255));
        if (c == UART_BR_CMD_WR || c == UART_BR_CMD_RD) c = 8'h00;
      end else begin
        c = ($urandom_range(0, 1) != 0) ? UART_BR_CMD_WR : UART_BR_CMD_RD;
      end
      do_frame(c, ra, $urandom, int'($urandom_range(1, 4)), k == 1, 3, 1'b0,
               $sformatf("rnd%0d", n));
    end

    chk("tx_gating", 64'(gate_err), 64'd0);
    chk("req_stable", 64'(unstable), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
